ram_16x8_prog: RTL and testbench

RAM_16X8_PROG -- requirements
Module: ram_16x8_prog

---
 rtl/ram_16x8_prog_if.sv | 24 ++
 rtl/ram_16x8_prog.sv | 86 ++++++++
 tb/tb_ram_16x8_prog.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ram_16x8_prog_if.sv
// Bus bundle for the 16-location programmable RAM.
// The master is the control unit or bench; the slave is the RAM.
interface ram_16x8_prog_if #(
  parameter int DATA_W = 8
) ();
  logic [3:0]        addr;
  logic              run_prog;
  logic              Ce;
  logic [DATA_W-1:0] prog_data;
  logic              prog_we;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              busy;

  modport master (
    output addr, run_prog, Ce, prog_data, prog_we,
    input  bus_out, bus_oe, busy
  );

  modport slave (
    input  addr, run_prog, Ce, prog_data, prog_we,
    output bus_out, bus_oe, busy
  );
endinterface

// File: rtl/ram_16x8_prog.sv
// 16 x DATA_W program RAM with a clear-after-reset sequence, a manual
// write button that writes once per press, and a registered bus read port.
module ram_16x8_prog #(
  parameter int DATA_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  ram_16x8_prog_if.slave bus
);

  localparam logic [1:0] S_CLEAR    = 2'd0;
  localparam logic [1:0] S_READY    = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_clr_ptr;
  logic              r_we_prev;
  logic [DATA_W-1:0] r_bus_out;
  logic              r_bus_oe;
  logic [DATA_W-1:0] r_mem [16];

  logic              w_busy;
  logic              w_press;
  logic              w_mem_we;
  logic [3:0]        w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_rd_en;

  assign w_busy = (r_state == S_CLEAR);

  // Rising edge of the button while idle in programming mode.
  assign w_press = (r_state == S_READY) && !bus.run_prog &&
                   bus.prog_we && !r_we_prev;

  // Reset never writes; the clear sequence owns the port while busy.
  assign w_mem_we    = !reset && (w_busy || w_press);
  assign w_mem_addr  = w_busy ? r_clr_ptr : bus.addr;
  assign w_mem_wdata = w_busy ? '0 : bus.prog_data;

  assign w_rd_en = bus.run_prog && !bus.Ce && !w_busy;

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      r_clr_ptr <= 4'd0;
      r_we_prev <= 1'b1;
      r_bus_out <= '0;
      r_bus_oe  <= 1'b0;
    end else begin
      r_we_prev <= bus.prog_we;
      r_bus_oe  <= w_rd_en;
      r_bus_out <= w_rd_en ? r_mem[bus.addr] : '0;
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 4'd1;
          if (r_clr_ptr == 4'd15) begin
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (w_press) begin
            r_state <= S_WAIT_REL;
          end
        end
        S_WAIT_REL: begin
          if (!bus.prog_we) begin
            r_state <= S_READY;
          end
        end
        default: r_state <= S_READY;
      endcase
    end
  end

  assign bus.bus_out = r_bus_out;
  assign bus.bus_oe  = r_bus_oe;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_ram_16x8_prog.sv
// Scoreboard bench for ram_16x8_prog: each driven cycle queues the expected
// {busy, bus_oe, bus_out} for the following edge; a negedge monitor checks it.
module tb_ram_16x8_prog;

  typedef struct {
    int         due;
    logic [9:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  int         cycle_cnt = 0;
  int         n_checks = 0;
  int         n_fails = 0;
  exp_t       exp_q [$];
  logic [7:0] model_mem [16];

  ram_16x8_prog_if #(.DATA_W(8)) u_if ();

  ram_16x8_prog #(.DATA_W(8), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clock (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_value(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cycle_cnt);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", tag, act, cycle_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].due == cycle_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        check_value(e.tag, {22'd0, u_if.busy, u_if.bus_oe, u_if.bus_out}, {22'd0, e.val});
      end else if (exp_q[0].due < cycle_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        check_value({e.tag, "_sched"}, cycle_cnt, e.due);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic drive(input string tag, input logic rst, input logic run,
                       input logic ce, input logic [3:0] a, input logic [7:0] d,
                       input logic we, input logic eb, input logic eo,
                       input logic [7:0] ed);
    exp_t e;
    reset            = rst;
    u_if.run_prog    = run;
    u_if.Ce          = ce;
    u_if.addr        = a;
    u_if.prog_data   = d;
    u_if.prog_we     = we;
    e.due = cycle_cnt + 1;
    e.val = {eb, eo, ed};
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.run_prog  = 1'b1;
    u_if.Ce        = 1'b0;
    u_if.addr      = 4'd0;
    u_if.prog_data = 8'd0;
    u_if.prog_we   = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset, then 16 busy cycles; run_prog wiggles without effect.
    drive("rst", 1, 1, 0, 4'd0, 8'h00, 0, 1, 0, 8'h00);
    for (int i = 0; i < 15; i++)
      drive("clr", 0, (i % 2 == 0), 0, 4'(i), 8'h00, 0, 1, 0, 8'h00);
    drive("clr_end", 0, 1, 0, 4'd0, 8'h00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++)
      drive("rd_zero", 0, 1, 0, 4'(i), 8'h00, 0, 0, 1, model_mem[i]);

    // Held press with data changing mid-press: only the first value lands.
    for (int k = 0; k < 5; k++)
      drive("prs3", 0, 0, 0, 4'd3, (k < 2) ? 8'hA5 : 8'h11, 1, 0, 0, 8'h00);
    model_mem[3] = 8'hA5;
    drive("rel3", 0, 0, 0, 4'd3, 8'h11, 0, 0, 0, 8'h00);
    drive("rd3", 0, 1, 0, 4'd3, 8'h00, 0, 0, 1, model_mem[3]);

    // Single-cycle press at addr 7.
    drive("prs7", 0, 0, 0, 4'd7, 8'h3C, 1, 0, 0, 8'h00);
    model_mem[7] = 8'h3C;
    drive("rel7", 0, 0, 0, 4'd7, 8'h00, 0, 0, 0, 8'h00);

    // Address changes while running show up one cycle later.
    drive("rd_a3", 0, 1, 0, 4'd3, 8'h00, 0, 0, 1, model_mem[3]);
    drive("rd_a7", 0, 1, 0, 4'd7, 8'h00, 0, 0, 1, model_mem[7]);
    drive("rd_a0", 0, 1, 0, 4'd0, 8'h00, 0, 0, 1, model_mem[0]);
    drive("rd_a7b", 0, 1, 0, 4'd7, 8'h00, 0, 0, 1, model_mem[7]);

    // Button pulse in run mode must not write.
    drive("run_we", 0, 1, 0, 4'd5, 8'hFF, 1, 0, 1, model_mem[5]);
    drive("run_rel", 0, 1, 0, 4'd5, 8'hFF, 0, 0, 1, model_mem[5]);
    drive("ce_off", 0, 1, 1, 4'd7, 8'h00, 0, 0, 0, 8'h00);
    drive("rd5", 0, 1, 0, 4'd5, 8'h00, 0, 0, 1, model_mem[5]);
    drive("prog_off", 0, 0, 0, 4'd7, 8'h00, 0, 0, 0, 8'h00);

    // Reset at clear cycle 7 with the button held throughout.
    drive("rst2", 1, 0, 0, 4'd9, 8'h77, 1, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++)
      drive("clr_a", 0, 0, 0, 4'd9, 8'h77, 1, 1, 0, 8'h00);
    drive("rst3", 1, 0, 0, 4'd9, 8'h77, 1, 1, 0, 8'h00);
    for (int i = 0; i < 15; i++)
      drive("clr_b", 0, 0, 0, 4'd9, 8'h77, 1, 1, 0, 8'h00);
    drive("clr_b_end", 0, 0, 0, 4'd9, 8'h77, 1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    drive("hold1", 0, 0, 0, 4'd9, 8'h77, 1, 0, 0, 8'h00);
    drive("hold2", 0, 0, 0, 4'd9, 8'h77, 1, 0, 0, 8'h00);
    drive("rel9", 0, 0, 0, 4'd9, 8'h77, 0, 0, 0, 8'h00);
    drive("rd9_clr", 0, 1, 0, 4'd9, 8'h00, 0, 0, 1, model_mem[9]);
    drive("rd3_clr", 0, 1, 0, 4'd3, 8'h00, 0, 0, 1, model_mem[3]);
    drive("rd7_clr", 0, 1, 0, 4'd7, 8'h00, 0, 0, 1, model_mem[7]);

    // Fresh press after release now writes.
    drive("idle9", 0, 0, 0, 4'd9, 8'h77, 0, 0, 0, 8'h00);
    drive("prs9", 0, 0, 0, 4'd9, 8'h77, 1, 0, 0, 8'h00);
    model_mem[9] = 8'h77;
    drive("rel9b", 0, 0, 0, 4'd9, 8'h00, 0, 0, 0, 8'h00);
    drive("rd9", 0, 1, 0, 4'd9, 8'h00, 0, 0, 1, model_mem[9]);
    drive("rd8", 0, 1, 0, 4'd8, 8'h00, 0, 0, 1, model_mem[8]);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) check_value("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
